uart_rx_word: RTL and testbench

Serial receiver at the far end of the UART link driven by the team's `uart_tx` transmitter. It samples an 8N1 line at the shared baud rate, validates start and stop bits, and assembles four consecutive bytes, least-significant byte first, into one 32-bit word. Each completed word is presented with a single-cycle `valid` strobe, so a downstream consumer (display or logger) can capture meter words such as `datobase` sent by the transmitting board.

---
 rtl/uart_rx_word.sv | 143 ++++++++++++++
 tb/tb_uart_rx_word.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that assembles four bytes, LSB first, into one 32-bit word.
// Start/stop validation, partial-word timeout and framing-error recovery included.
module uart_rx_word #(
    parameter int unsigned BAUD    = 104,
    parameter int unsigned TIMEOUT = 20 * BAUD
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_rx,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_frame_err,
    output logic        o_busy
);
    localparam int unsigned BW = $clog2(BAUD);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] HALF_LD = BW'(BAUD / 2 - 1);
    localparam logic [BW-1:0] FULL_LD = BW'(BAUD - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [1:0]    r_sync;
    state_e        r_state;
    logic [BW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_cnt;
    logic [1:0]    r_byte_cnt;
    logic [7:0]    r_shift;
    logic [23:0]   r_word;
    logic [TW-1:0] r_to_cnt;
    logic          r_armed;
    logic [31:0]   r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_busy;

    logic w_rx_s;
    logic w_baud_done;

    assign w_rx_s      = r_sync[1];
    assign w_baud_done = (r_baud_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= StIdle;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_word      <= '0;
            r_to_cnt    <= '0;
            r_armed     <= 1'b1;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            if (!w_baud_done) begin
                r_baud_cnt <= r_baud_cnt - 1'b1;
            end
            case (r_state)
                StIdle: begin
                    // After a bad stop bit the line must go high before a new start counts
                    if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end
                    if (r_armed && !w_rx_s) begin
                        r_state    <= StStart;
                        r_bit_cnt  <= '0;
                        r_baud_cnt <= HALF_LD;
                        r_busy     <= 1'b1;
                    end else if (r_byte_cnt != '0) begin
                        if (r_to_cnt == TO_LAST) begin
                            r_byte_cnt <= '0;
                            r_to_cnt   <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                end
                StStart: begin
                    if (w_baud_done) begin
                        if (w_rx_s) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= StData;
                            r_baud_cnt <= FULL_LD;
                        end
                    end
                end
                StData: begin
                    if (w_baud_done) begin
                        r_shift    <= {w_rx_s, r_shift[7:1]};
                        r_baud_cnt <= FULL_LD;
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (w_baud_done) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        if (w_rx_s) begin
                            r_to_cnt   <= '0;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            if (r_byte_cnt == 2'd3) begin
                                r_data  <= {r_shift, r_word};
                                r_valid <= 1'b1;
                            end else begin
                                r_word[{r_byte_cnt, 3'b000} +: 8] <= r_shift;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_byte_cnt  <= '0;
                            r_to_cnt    <= '0;
                            r_armed     <= 1'b0;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: serial bytes in, expected words queued and
// compared when valid pulses.
module tb_uart_rx_word;
    localparam int unsigned BAUD    = 104;
    localparam int unsigned TIMEOUT = 20 * BAUD;

    logic        clk;
    logic        rstn;
    logic        rx;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_frame_err;
    logic        o_busy;

    int          n_vec;
    int          n_err;
    int          n_ferr;
    int          n0;
    int          cyc;
    int          t_prev;
    int          t_last;
    logic        prev_valid;
    logic [31:0] exp_q[$];

    uart_rx_word #(
        .BAUD    (BAUD),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_rx        (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock step; checks every valid pulse against the scoreboard.
    task automatic tick();
        logic [31:0] w_exp;
        @(negedge clk);
        cyc++;
        if (o_valid) begin
            chk("valid_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                w_exp = exp_q.pop_front();
                chk("word", o_data, w_exp);
            end
            chk("valid_ferr_exclusive", 32'(o_frame_err), 32'd0);
            chk("valid_one_cycle", 32'(prev_valid), 32'd0);
            t_prev = t_last;
            t_last = cyc;
        end
        if (o_frame_err) n_ferr++;
        prev_valid = o_valid;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BAUD) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, input int idle_bits);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_v);
        for (int i = 0; i < idle_bits; i++) send_bit(1'b1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3 * int'(BAUD) && exp_q.size() != 0; i++) tick();
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_ferr = 0; cyc = 0;
        t_prev = 0; t_last = 0; prev_valid = 1'b0;
        rx = 1'b1;
        rstn = 1'b0;
        repeat (5) tick();
        chk("reset_data", o_data, 32'd0);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_ferr", 32'(o_frame_err), 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);
        rstn = 1'b1;
        repeat (2 * BAUD) tick();

        // Basic word, one idle bit between bytes
        n0 = n_ferr;
        exp_q.push_back(32'hDEADBEEF);
        send_byte(8'hEF, 1'b1, 1);
        send_byte(8'hBE, 1'b1, 1);
        send_byte(8'hAD, 1'b1, 1);
        send_byte(8'hDE, 1'b1, 1);
        drain("t1_drain");
        chk("t1_data", o_data, 32'hDEADBEEF);
        chk("t1_no_ferr", 32'(n_ferr - n0), 32'd0);

        // Short glitch mid-word must not disturb the byte count
        exp_q.push_back(32'hC33CA55A);
        send_byte(8'h5A, 1'b1, 1);
        send_byte(8'hA5, 1'b1, 1);
        rx = 1'b0;
        repeat (10) tick();
        rx = 1'b1;
        repeat (10) tick();
        chk("t2_busy_glitch", 32'(o_busy), 32'd1);
        repeat (60) tick();
        chk("t2_busy_released", 32'(o_busy), 32'd0);
        chk("t2_no_valid", 32'(exp_q.size()), 32'd1);
        send_byte(8'h3C, 1'b1, 1);
        send_byte(8'hC3, 1'b1, 1);
        drain("t2_drain");
        chk("t2_data", o_data, 32'hC33CA55A);

        // Framing error then a clean word
        n0 = n_ferr;
        send_byte(8'h55, 1'b0, 2);
        chk("t3_ferr_count", 32'(n_ferr - n0), 32'd1);
        chk("t3_data_held", o_data, 32'hC33CA55A);
        exp_q.push_back(32'h04030201);
        send_byte(8'h01, 1'b1, 1);
        send_byte(8'h02, 1'b1, 1);
        send_byte(8'h03, 1'b1, 1);
        send_byte(8'h04, 1'b1, 1);
        drain("t3_drain");
        chk("t3_data", o_data, 32'h04030201);

        // Partial word abandoned by timeout
        exp_q.push_back(32'h44332211);
        send_byte(8'hAA, 1'b1, 1);
        send_byte(8'hBB, 1'b1, 1);
        repeat (TIMEOUT + 5) tick();
        send_byte(8'h11, 1'b1, 1);
        send_byte(8'h22, 1'b1, 1);
        send_byte(8'h33, 1'b1, 1);
        send_byte(8'h44, 1'b1, 1);
        drain("t4_drain");
        chk("t4_data", o_data, 32'h44332211);

        // Reset in the middle of the third byte
        send_byte(8'hA1, 1'b1, 1);
        send_byte(8'hB2, 1'b1, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("t5_busy_mid", 32'(o_busy), 32'd1);
        rstn = 1'b0;
        rx = 1'b1;
        repeat (4) tick();
        chk("t5_reset_data", o_data, 32'd0);
        chk("t5_reset_busy", 32'(o_busy), 32'd0);
        chk("t5_reset_valid", 32'(o_valid), 32'd0);
        rstn = 1'b1;
        repeat (2 * BAUD) tick();
        exp_q.push_back(32'h12345678);
        send_byte(8'h78, 1'b1, 1);
        send_byte(8'h56, 1'b1, 1);
        send_byte(8'h34, 1'b1, 1);
        send_byte(8'h12, 1'b1, 1);
        drain("t5_drain");
        chk("t5_data", o_data, 32'h12345678);

        // Back-to-back frames, zero idle
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'h0BADBEEF);
        send_byte(8'h0D, 1'b1, 0);
        send_byte(8'hF0, 1'b1, 0);
        send_byte(8'hFE, 1'b1, 0);
        send_byte(8'hCA, 1'b1, 0);
        send_byte(8'hEF, 1'b1, 0);
        send_byte(8'hBE, 1'b1, 0);
        send_byte(8'hAD, 1'b1, 0);
        send_byte(8'h0B, 1'b1, 0);
        drain("t6_drain");
        chk("t6_data", o_data, 32'h0BADBEEF);
        chk("t6_spacing", 32'(t_last - t_prev), 32'(40 * BAUD));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
